// File: rtl/pipeline_ctrl_pkg.sv
// Shared state encodings and debug command codes for the pipeline run controller.
package pipeline_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StRun    = 3'd1,
        StStep   = 3'd2,
        StPause  = 3'd3,
        StHalted = 3'd4
    } state_e;

    localparam logic [1:0] CMD_NOP  = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous active-high reset that saturates at all-ones.
module sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_enable,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_enable && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_count = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Debug run/step/stop controller broadcasting start and advance enables to the pipeline.
module pipeline_run_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [1:0]           i_cmd,
    output logic                 o_cmd_ready,
    input  logic                 i_halt,
    output logic                 o_start,
    output logic                 o_step,
    output logic [2:0]           o_state,
    output logic                 o_halted,
    output logic [CNT_WIDTH-1:0] o_step_count
);

    state_e state_q;
    state_e state_d;
    logic   cmd_ready;
    logic   step_en;
    logic   cmd_accept;

    always_comb begin
        cmd_ready  = !i_halt && ((state_q == StIdle) || (state_q == StPause) ||
                                 (state_q == StRun));
        step_en    = !i_halt && ((state_q == StRun) || (state_q == StStep));
        cmd_accept = i_cmd_valid && cmd_ready;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle, StPause: begin
                // Halt is only honoured once the pipeline has been started.
                if ((state_q == StPause) && i_halt) begin
                    state_d = StHalted;
                end else if (cmd_accept && (i_cmd == CMD_RUN)) begin
                    state_d = StRun;
                end else if (cmd_accept && (i_cmd == CMD_STEP)) begin
                    state_d = StStep;
                end
            end
            StRun: begin
                if (i_halt) begin
                    state_d = StHalted;
                end else if (cmd_accept && (i_cmd == CMD_STOP)) begin
                    state_d = StPause;
                end
            end
            StStep: begin
                state_d = i_halt ? StHalted : StPause;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_step_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_enable(step_en),
        .o_count (o_step_count)
    );

    assign o_cmd_ready = cmd_ready;
    assign o_step      = step_en;
    assign o_start     = (state_q != StIdle);
    assign o_halted    = (state_q == StHalted);
    assign o_state     = state_q;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Scoreboard bench: a per-cycle reference model queues expected outputs, a monitor compares them.
module tb_pipeline_run_ctrl;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic [1:0]  i_cmd = 2'b00;
    logic        i_halt = 1'b0;

    logic        o_cmd_ready, o_start, o_step, o_halted;
    logic [2:0]  o_state;
    logic [31:0] o_step_count;
    logic        n_cmd_ready, n_start, n_step, n_halted;
    logic [2:0]  n_state;
    logic [3:0]  n_step_count;

    always #5 i_clock = ~i_clock;

    pipeline_run_ctrl dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .o_cmd_ready (o_cmd_ready),
        .i_halt      (i_halt),
        .o_start     (o_start),
        .o_step      (o_step),
        .o_state     (o_state),
        .o_halted    (o_halted),
        .o_step_count(o_step_count)
    );

    pipeline_run_ctrl #(
        .CNT_WIDTH(4)
    ) dut_narrow (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_cmd_valid (i_cmd_valid),
        .i_cmd       (i_cmd),
        .o_cmd_ready (n_cmd_ready),
        .i_halt      (i_halt),
        .o_start     (n_start),
        .o_step      (n_step),
        .o_state     (n_state),
        .o_halted    (n_halted),
        .o_step_count(n_step_count)
    );

    typedef struct packed {
        logic        ready;
        logic        start;
        logic        step;
        logic        halted;
        logic [2:0]  state;
        logic [31:0] count;
        logic [3:0]  count4;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;

    // Reference model: state as a plain integer 0..4, counts as running totals.
    int          m_state;
    bit          m_known = 0;
    longint      m_steps;

    task automatic drive(input bit rst, input bit valid, input logic [1:0] cmd, input bit halt);
        obs_t e;
        bit   rdy, stp;
        @(posedge i_clock);
        #1;
        i_reset = rst; i_cmd_valid = valid; i_cmd = cmd; i_halt = halt;
        cycle++;
        if (m_known) begin
            rdy = !halt && (m_state == 0 || m_state == 1 || m_state == 3);
            stp = !halt && (m_state == 1 || m_state == 2);
            e.ready  = rdy;
            e.start  = (m_state != 0);
            e.step   = stp;
            e.halted = (m_state == 4);
            e.state  = 3'(m_state);
            e.count  = 32'(m_steps);
            e.count4 = (m_steps > 15) ? 4'd15 : 4'(m_steps);
            exp_q.push_back(e);
            if (!rst) begin
                if (stp) m_steps++;
                if (halt && m_state >= 1 && m_state <= 3) m_state = 4;
                else if (m_state == 2) m_state = 3;
                else if (valid && rdy) begin
                    if ((m_state == 0 || m_state == 3) && cmd == 2'b01) m_state = 1;
                    else if ((m_state == 0 || m_state == 3) && cmd == 2'b10) m_state = 2;
                    else if (m_state == 1 && cmd == 2'b11) m_state = 3;
                end
            end
        end
        if (rst) begin
            m_state = 0;
            m_steps = 0;
            m_known = 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 2'b00, 0);
    endtask

    // Monitor: every cycle the DUT presents a fresh output set mid-period.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge i_clock);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = '{o_cmd_ready, o_start, o_step, o_halted, o_state, o_step_count, n_step_count};
                n_checks++;
                if (a !== e || n_state !== e.state || n_step !== e.step ||
                    n_cmd_ready !== e.ready || n_start !== e.start || n_halted !== e.halted) begin
                    n_fail++;
                    $display("FAIL cycle_%0d outputs: got rdy=%b start=%b step=%b halt=%b st=%0d cnt=%0d cnt4=%0d (narrow st=%0d step=%b) expected rdy=%b start=%b step=%b halt=%b st=%0d cnt=%0d cnt4=%0d",
                             cycle, a.ready, a.start, a.step, a.halted, a.state, a.count,
                             a.count4, n_state, n_step, e.ready, e.start, e.step, e.halted,
                             e.state, e.count, e.count4);
                end
            end
        end
    end

    initial begin
        drive(1, 0, 2'b00, 0);
        drive(1, 1, 2'b01, 1);
        idle(2);
        // Single step from IDLE.
        drive(0, 1, 2'b10, 0);
        idle(3);
        // Free-run 10 cycles, then STOP.
        drive(0, 1, 2'b01, 0);
        idle(9);
        drive(0, 1, 2'b11, 0);
        idle(2);
        // Run into saturation of the narrow counter, then halt with a coincident STOP.
        drive(0, 1, 2'b01, 0);
        idle(20);
        drive(0, 1, 2'b11, 1);
        for (int i = 0; i < 4; i++) drive(0, 1, 2'b01, i[0]);
        // Reset in the middle of a run.
        drive(1, 0, 2'b00, 0);
        drive(0, 1, 2'b01, 0);
        idle(5);
        drive(1, 1, 2'b11, 1);
        idle(2);
        // Halt ignored in IDLE, then a normal single step.
        drive(0, 1, 2'b01, 1);
        drive(0, 0, 2'b00, 1);
        drive(0, 1, 2'b10, 0);
        idle(3);
        // Randomised traffic with occasional halts and resets.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 59) == 0), $urandom_range(0, 1),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 29) == 0));
        end
        idle(1);
        @(negedge i_clock);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
